// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the round-robin SRAM client-port arbiter.
// Optional downstream ack timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] DEAD_WORD = 16'hDEAD;

  localparam int DEF_ADR_W  = 18;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_SEL_W  = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and ram-side signals of mem_arbiter bundled in one interface.
// The err flag exists only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int ADR_W  = mem_arb_pkg::DEF_ADR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W,
  parameter int SEL_W  = mem_arb_pkg::DEF_SEL_W
);

  logic [NREQ-1:0]        r_req;
  logic [NREQ*ADR_W-1:0]  r_adr;
  logic [NREQ-1:0]        r_write;
  logic [NREQ*SEL_W-1:0]  r_sel;
  logic [NREQ*DATA_W-1:0] r_wdata;
  logic [NREQ-1:0]        r_ack;
  logic [DATA_W-1:0]      r_rdata;

  logic [ADR_W-1:0]       d_adr;
  logic                   d_req;
  logic                   d_write;
  logic [SEL_W-1:0]       d_sel;
  logic [DATA_W-1:0]      d_wdata;
  logic                   d_ack;
  logic [DATA_W-1:0]      d_rdata;

  logic [NREQ-1:0]        grant;
  logic                   busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic                   err;
`endif

  // The arbiter takes the slave view because requesters initiate every transaction.
  modport slave (
    input  r_req, r_adr, r_write, r_sel, r_wdata, d_ack, d_rdata,
    output r_ack, r_rdata, d_adr, d_req, d_write, d_sel, d_wdata, grant, busy
`ifdef MEM_ARB_TIMEOUT_EN
    , output err
`endif
  );

  modport master (
    output r_req, r_adr, r_write, r_sel, r_wdata, d_ack, d_rdata,
    input  r_ack, r_rdata, d_adr, d_req, d_write, d_sel, d_wdata, grant, busy
`ifdef MEM_ARB_TIMEOUT_EN
    , input err
`endif
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above 'last', wrapping.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan last+1 .. last+NREQ so the previous winner is considered last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NREQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SRAM client port among NREQ requesters.
// Define MEM_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT busy cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int ADR_W   = DEF_ADR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d, gidx_q, gidx_d;
  logic [NREQ-1:0]   grant_q, grant_d, ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              write_q, write_d, req_q, req_d, busy_q, busy_d;
  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.r_req),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    write_d = write_q;
    req_d   = req_q;
    busy_d  = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.r_req) begin
          adr_d   = bus.r_adr[int'(pick_idx)*ADR_W +: ADR_W];
          write_d = bus.r_write[pick_idx];
          sel_d   = bus.r_sel[int'(pick_idx)*SEL_W +: SEL_W];
          wdata_d = bus.r_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          req_d   = 1'b1;
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // A real ack takes precedence over a timeout landing in the same cycle.
        if (bus.d_ack) begin
          req_d   = 1'b0;
          ack_d   = grant_q;
          rdata_d = bus.d_rdata;
          last_d  = gidx_q;
          state_d = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          ack_d   = grant_q;
          rdata_d = DATA_W'(DEAD_WORD);
          last_d  = gidx_q;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        ack_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NREQ - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      adr_q   <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.r_ack   = ack_q;
  assign bus.r_rdata = rdata_q;
  assign bus.d_adr   = adr_q;
  assign bus.d_req   = req_q;
  assign bus.d_write = write_q;
  assign bus.d_sel   = sel_q;
  assign bus.d_wdata = wdata_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.err     = err_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a simple ram responder model.
// Timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int NREQ   = 3;
  localparam int ADR_W  = 18;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 2;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic ram_en;
  int   ram_delay;
  int   seen;
  logic ram_ack;
  logic spur_ack;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NREQ(NREQ), .ADR_W(ADR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  assign bus.d_ack = ram_ack | spur_ack;

  mem_arbiter #(
    .NREQ(NREQ), .ADR_W(ADR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADR_W-1:0] a);
    return a[15:0] ^ 16'h1224;
  endfunction

  // Ram model: acks ram_delay cycles after d_req is first seen, data derived from address.
  initial begin
    ram_ack     = 1'b0;
    bus.d_rdata = '0;
    seen        = 0;
    forever begin
      @(posedge clk);
      #1;
      ram_ack = 1'b0;
      if (bus.d_req === 1'b1 && ram_en) begin
        if (seen == ram_delay) begin
          ram_ack     = 1'b1;
          bus.d_rdata = ram_word(bus.d_adr);
        end
        seen++;
      end else if (bus.d_req !== 1'b1) begin
        seen = 0;
      end
    end
  end

  task automatic set_req(input int i, input logic rq, input logic [ADR_W-1:0] a,
                         input logic wr, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] wd);
    bus.r_req[i]                     = rq;
    bus.r_adr[i*ADR_W +: ADR_W]      = a;
    bus.r_write[i]                   = wr;
    bus.r_sel[i*SEL_W +: SEL_W]      = s;
    bus.r_wdata[i*DATA_W +: DATA_W]  = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.r_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Waits for an r_ack pulse, capturing the d_* payload and whether it stayed stable.
  task automatic wait_ack(output logic [NREQ-1:0] ack, output logic [DATA_W-1:0] data,
                          output logic [NREQ-1:0] gnt, output logic [ADR_W-1:0] adr,
                          output logic wr, output logic [SEL_W-1:0] sel,
                          output logic [DATA_W-1:0] wd, output bit stable,
                          output bit tmo, output int nbusy);
    bit got;
    ack = '0; data = '0; gnt = '0; adr = '0; wr = 1'b0; sel = '0; wd = '0;
    stable = 1'b1; tmo = 1'b1; nbusy = 0; got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.r_ack !== '0) begin
        ack  = bus.r_ack;
        data = bus.r_rdata;
        tmo  = 1'b0;
        break;
      end
      if (bus.d_req === 1'b1) begin
        nbusy++;
        if (!got) begin
          got = 1'b1;
          gnt = bus.grant; adr = bus.d_adr; wr = bus.d_write; sel = bus.d_sel; wd = bus.d_wdata;
        end else if ({bus.grant, bus.d_adr, bus.d_write, bus.d_sel, bus.d_wdata} !== {gnt, adr, wr, sel, wd}) begin
          stable = 1'b0;
        end
      end
    end
  endtask

  logic [NREQ-1:0]   t_ack, t_gnt;
  logic [DATA_W-1:0] t_data, t_wd;
  logic [ADR_W-1:0]  t_adr;
  logic              t_wr;
  logic [SEL_W-1:0]  t_sel;
  bit                t_stable, t_tmo;
  int                t_nbusy;

  task automatic test_reset();
    rst = 1'b1;
    bus.r_req = '0; bus.r_adr = '0; bus.r_write = '0; bus.r_sel = '0; bus.r_wdata = '0;
    ram_en = 1'b1; ram_delay = 2; spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.d_req, bus.grant, bus.r_ack, bus.busy, bus.d_write} !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {bus.d_req, bus.grant, bus.r_ack, bus.busy, bus.d_write}); end
    checks++; if (bus.d_adr !== '0) begin errors++; $display("[TB] FAIL reset_adr: got %h expected 0", bus.d_adr); end
    checks++; if ({bus.r_rdata, bus.d_wdata, bus.d_sel} !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got %h expected 0", {bus.r_rdata, bus.d_wdata, bus.d_sel}); end
`ifdef MEM_ARB_TIMEOUT_EN
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_read();
    ram_delay = 2;
    set_req(0, 1'b1, 18'h00010, 1'b0, 2'b00, 16'h0000);
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if (t_tmo !== 1'b0) begin errors++; $display("[TB] FAIL read_wait: got timeout expected ack"); end
    checks++; if (t_gnt !== 3'b001) begin errors++; $display("[TB] FAIL read_grant: got %b expected 001", t_gnt); end
    checks++; if ({t_adr, t_wr} !== {18'h00010, 1'b0}) begin
      errors++; $display("[TB] FAIL read_payload: got %h/%b expected 00010/0", t_adr, t_wr); end
    checks++; if (t_ack !== 3'b001) begin errors++; $display("[TB] FAIL read_ack: got %b expected 001", t_ack); end
    checks++; if (t_data !== 16'h1234) begin errors++; $display("[TB] FAIL read_data: got %h expected 1234", t_data); end
    checks++; if (t_nbusy != 3) begin errors++; $display("[TB] FAIL read_dreq_cycles: got %0d expected 3", t_nbusy); end
    @(posedge clk); #1;
    bus.r_req[0] = 1'b0;
    @(negedge clk);
    checks++; if ({bus.r_ack, bus.grant, bus.busy} !== 7'b0) begin
      errors++; $display("[TB] FAIL read_release: got %b expected 0", {bus.r_ack, bus.grant, bus.busy}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ram_delay = 1;
    set_req(0, 1'b1, 18'h00100, 1'b0, 2'b11, 16'h0000);
    set_req(2, 1'b1, 18'h20200, 1'b1, 2'b01, 16'hBEEF);
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if ({t_tmo, t_ack, t_gnt} !== {1'b0, 3'b001, 3'b001}) begin
      errors++; $display("[TB] FAIL simul_first: got ack %b grant %b expected 001/001", t_ack, t_gnt); end
    checks++; if ({t_adr, t_wr, t_sel, t_stable} !== {18'h00100, 1'b0, 2'b11, 1'b1}) begin
      errors++; $display("[TB] FAIL simul_first_payload: got %h/%b/%b stable %b", t_adr, t_wr, t_sel, t_stable); end
    checks++; if (t_data !== ram_word(18'h00100)) begin
      errors++; $display("[TB] FAIL simul_first_data: got %h expected %h", t_data, ram_word(18'h00100)); end
    @(posedge clk); #1;
    bus.r_req[0] = 1'b0;
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if ({t_tmo, t_ack, t_gnt} !== {1'b0, 3'b100, 3'b100}) begin
      errors++; $display("[TB] FAIL simul_second: got ack %b grant %b expected 100/100", t_ack, t_gnt); end
    checks++; if ({t_adr, t_wr, t_sel, t_wd, t_stable} !== {18'h20200, 1'b1, 2'b01, 16'hBEEF, 1'b1}) begin
      errors++; $display("[TB] FAIL simul_second_payload: got %h/%b/%b/%h stable %b", t_adr, t_wr, t_sel, t_wd, t_stable); end
    @(posedge clk); #1;
    bus.r_req[2] = 1'b0;
  endtask

  task automatic test_saturation();
    logic [NREQ-1:0] exp_g;
    ram_delay = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 18'h01000 + 18'(i * 16), 1'b0, 2'b11, 16'h0000);
    for (int k = 0; k < 9; k++) begin
      exp_g = 3'b001 << (k % 3);
      wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
      checks++; if ({t_tmo, t_gnt, t_ack} !== {1'b0, exp_g, exp_g}) begin
        errors++; $display("[TB] FAIL sat_order_%0d: got grant %b ack %b expected %b", k, t_gnt, t_ack, exp_g); end
      checks++; if (t_data !== ram_word(18'h01000 + 18'((k % 3) * 16))) begin
        errors++; $display("[TB] FAIL sat_data_%0d: got %h expected %h", k, t_data, ram_word(18'h01000 + 18'((k % 3) * 16))); end
    end
    @(posedge clk); #1;
    bus.r_req = '0;
  endtask

  task automatic test_write();
    int pulses;
    ram_delay = 4;
    set_req(1, 1'b1, 18'h3FFFF, 1'b1, 2'b10, 16'hA55A);
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if ({t_tmo, t_gnt, t_ack} !== {1'b0, 3'b010, 3'b010}) begin
      errors++; $display("[TB] FAIL write_ack: got grant %b ack %b expected 010/010", t_gnt, t_ack); end
    checks++; if ({t_adr, t_wr, t_sel, t_wd} !== {18'h3FFFF, 1'b1, 2'b10, 16'hA55A}) begin
      errors++; $display("[TB] FAIL write_payload: got %h/%b/%b/%h expected 3ffff/1/10/a55a", t_adr, t_wr, t_sel, t_wd); end
    checks++; if (t_stable !== 1'b1) begin errors++; $display("[TB] FAIL write_stable: got %b expected 1", t_stable); end
    checks++; if (t_nbusy != 5) begin errors++; $display("[TB] FAIL write_dreq_cycles: got %0d expected 5", t_nbusy); end
    @(posedge clk); #1;
    bus.r_req[1] = 1'b0;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (bus.r_ack !== '0) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL write_single_ack: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_drop_during_busy();
    ram_delay = 3;
    set_req(2, 1'b1, 18'h00042, 1'b0, 2'b11, 16'h0000);
    for (int n = 0; n < 10; n++) begin @(negedge clk); if (bus.d_req === 1'b1) break; end
    bus.r_req[2] = 1'b0;
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if ({t_tmo, t_ack} !== {1'b0, 3'b100}) begin
      errors++; $display("[TB] FAIL drop_ack: got tmo %b ack %b expected 0/100", t_tmo, t_ack); end
    checks++; if (t_data !== ram_word(18'h00042)) begin
      errors++; $display("[TB] FAIL drop_data: got %h expected %h", t_data, ram_word(18'h00042)); end
    @(negedge clk);
    checks++; if ({bus.grant, bus.busy, bus.d_req} !== 5'b0) begin
      errors++; $display("[TB] FAIL drop_idle: got %b expected 0", {bus.grant, bus.busy, bus.d_req}); end
  endtask

  task automatic test_spurious_ack();
    int bad;
    @(posedge clk); #1;
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if ({bus.r_ack, bus.busy, bus.d_req} !== 5'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL idle_dack: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_async_reset();
    ram_en = 1'b0;
    @(posedge clk); #1;
    set_req(1, 1'b1, 18'h00077, 1'b0, 2'b11, 16'h0000);
    for (int n = 0; n < 10; n++) begin @(negedge clk); if (bus.d_req === 1'b1) break; end
    checks++; if (bus.d_req !== 1'b1) begin errors++; $display("[TB] FAIL arst_busy: got d_req %b expected 1", bus.d_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.d_req, bus.grant, bus.r_ack, bus.busy} !== 8'b0) begin
      errors++; $display("[TB] FAIL arst_clear: got %b expected 0", {bus.d_req, bus.grant, bus.r_ack, bus.busy}); end
    bus.r_req = '0;
    #1 rst = 1'b0;
    ram_en = 1'b1; ram_delay = 1;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 18'h00200 + 18'(i), 1'b0, 2'b11, 16'h0000);
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if ({t_tmo, t_gnt, t_ack} !== {1'b0, 3'b001, 3'b001}) begin
      errors++; $display("[TB] FAIL arst_first_win: got grant %b ack %b expected 001/001", t_gnt, t_ack); end
    @(posedge clk); #1;
    bus.r_req = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    ram_en = 1'b0;
    set_req(0, 1'b1, 18'h00005, 1'b0, 2'b11, 16'h0000);
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if ({t_tmo, t_ack} !== {1'b0, 3'b001}) begin
      errors++; $display("[TB] FAIL tmo_ack: got tmo %b ack %b expected 0/001", t_tmo, t_ack); end
    checks++; if (t_nbusy != 8) begin errors++; $display("[TB] FAIL tmo_cycles: got %0d expected 8", t_nbusy); end
    checks++; if (t_data !== 16'hDEAD) begin errors++; $display("[TB] FAIL tmo_data: got %h expected dead", t_data); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err: got %b expected 1", bus.err); end
    @(posedge clk); #1;
    bus.r_req[0] = 1'b0;
    ram_en = 1'b1; ram_delay = 1;
    set_req(1, 1'b1, 18'h00006, 1'b0, 2'b11, 16'h0000);
    wait_ack(t_ack, t_data, t_gnt, t_adr, t_wr, t_sel, t_wd, t_stable, t_tmo, t_nbusy);
    checks++; if ({t_tmo, t_ack, t_data} !== {1'b0, 3'b010, ram_word(18'h00006)}) begin
      errors++; $display("[TB] FAIL tmo_recover: got ack %b data %h", t_ack, t_data); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_sticky: got %b expected 1", bus.err); end
    @(posedge clk); #1;
    bus.r_req[1] = 1'b0;
    do_reset();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_rst_clear: got %b expected 0", bus.err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_saturation();
    test_write();
    test_drop_during_busy();
    test_spurious_ack();
    test_async_reset();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
